// File: rtl/beam_pkg.sv
// Shared types and defaults for the beam argmax stage, plus the
// index-to-angle conversion that the display bench also reuses.
package beam_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        CALC,
        DONE
    } state_e;

    localparam int DEF_NUM_BEAMS = 37;
    localparam int DEF_ENERGY_W  = 32;
    localparam int DEF_ANG_MIN   = -90;
    localparam int DEF_ANG_STEP  = 5;
    localparam int IDX_W         = $clog2(DEF_NUM_BEAMS);

    // The common 5-degree step avoids a multiplier: idx*5 == (idx<<2)+idx.
    function automatic logic signed [7:0] idx_to_angle(
        input logic [7:0] idx,
        input int         ang_min,
        input int         ang_step
    );
        logic signed [8:0] prod;
        if (ang_step == 5) begin
            prod = 9'(({1'b0, idx} << 2) + {1'b0, idx});
        end else begin
            prod = 9'(int'(idx) * ang_step);
        end
        return 8'(prod + 9'(ang_min));
    endfunction

endpackage

// File: rtl/beam_argmax.sv
// Scans one frame of beam energies, keeps the strongest (lowest index on ties)
// and reports its steering angle with a one-cycle wbdone pulse.
module beam_argmax
    import beam_pkg::*;
#(
    parameter int NUM_BEAMS = DEF_NUM_BEAMS,
    parameter int ENERGY_W  = DEF_ENERGY_W,
    parameter int ANG_MIN   = DEF_ANG_MIN,
    parameter int ANG_STEP  = DEF_ANG_STEP
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                e_valid,
    input  logic [ENERGY_W-1:0] e_data,
    output logic                e_ready,
    input  logic [ENERGY_W-1:0] thresh,
    output logic signed [7:0]   angle,
    output logic                detect,
    output logic                wbdone,
    output logic                busy,
    output logic                err_restart
);

    localparam int CNT_W = $clog2(NUM_BEAMS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BEAMS - 1);

    if ((ANG_MIN + ANG_STEP * (NUM_BEAMS - 1) > 127) || (ANG_MIN < -128)) begin : g_param_check
        $error("beam_argmax: angle range does not fit 8-bit signed");
    end

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      best_idx_q, best_idx_d;
    logic [ENERGY_W-1:0]   max_e_q, max_e_d;
    logic [ENERGY_W-1:0]   thresh_q, thresh_d;
    logic signed [7:0]     angle_q, angle_d;
    logic                  detect_q, detect_d;
    logic                  wbdone_q, wbdone_d;
    logic                  err_restart_q, err_restart_d;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        best_idx_d    = best_idx_q;
        max_e_d       = max_e_q;
        thresh_d      = thresh_q;
        angle_d       = angle_q;
        detect_d      = detect_q;
        wbdone_d      = 1'b0;
        err_restart_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SCAN;
                    count_d    = '0;
                    max_e_d    = '0;
                    best_idx_d = '0;
                    thresh_d   = thresh;
                end
            end
            SCAN: begin
                // A restart wins over a sample offered in the same cycle.
                if (start) begin
                    err_restart_d = 1'b1;
                    count_d       = '0;
                    max_e_d       = '0;
                    best_idx_d    = '0;
                    thresh_d      = thresh;
                end else if (e_valid) begin
                    if (count_q == '0 || e_data > max_e_q) begin
                        max_e_d    = e_data;
                        best_idx_d = count_q;
                    end
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_IDX) begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                angle_d  = idx_to_angle(8'(best_idx_q), ANG_MIN, ANG_STEP);
                detect_d = (max_e_q >= thresh_q);
                wbdone_d = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            best_idx_q    <= '0;
            max_e_q       <= '0;
            thresh_q      <= '0;
            angle_q       <= '0;
            detect_q      <= 1'b0;
            wbdone_q      <= 1'b0;
            err_restart_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            best_idx_q    <= best_idx_d;
            max_e_q       <= max_e_d;
            thresh_q      <= thresh_d;
            angle_q       <= angle_d;
            detect_q      <= detect_d;
            wbdone_q      <= wbdone_d;
            err_restart_q <= err_restart_d;
        end
    end

    assign e_ready     = (state_q == SCAN);
    assign busy        = (state_q == SCAN) || (state_q == CALC);
    assign angle       = angle_q;
    assign detect      = detect_q;
    assign wbdone      = wbdone_q;
    assign err_restart = err_restart_q;

endmodule

// File: doc/beam_argmax.md
Name: beam_argmax

Overview:
- Sits directly upstream of the angle display stage.
- Consumes one frame of per-steering-angle beam energies from the beamformer/weight block and finds the beam with maximum energy.
- Converts that beam index to a signed angle in degrees and presents it with a one-cycle done pulse (wbdone).
- The display stage latches angle on that pulse.

Parameters:
- NUM_BEAMS, 37, beams per frame (index 0..NUM_BEAMS-1).
- ENERGY_W, 32, width of an unsigned beam energy sample.
- ANG_MIN, -90, angle in degrees of beam index 0 (signed).
- ANG_STEP, 5, degrees between adjacent beams.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins a new frame scan.
- e_valid  in  1  energy sample valid.
- e_data  in  ENERGY_W  unsigned beam energy; beams arrive in index order 0..NUM_BEAMS-1.
- e_ready  out  1  block accepts a sample this cycle.
- thresh  in  ENERGY_W  minimum peak energy for a valid detection; sampled at start.
- angle  out  8  signed peak angle in degrees; holds between frames.
- detect  out  1  peak energy >= thresh for the last completed frame; holds.
- wbdone  out  1  one-cycle pulse; angle/detect updated this cycle.
- busy  out  1  high in SCAN and CALC.
- err_restart  out  1  one-cycle pulse when start aborts an in-progress frame.

Behaviour:
- Reset values: state IDLE, angle=0, detect=0, wbdone=0, busy=0, e_ready=0, err_restart=0. Internal count, max and best index are cleared.
- Reset mid-frame discards the frame; no wbdone is issued.
- States:
  - IDLE: e_ready=0. start -> SCAN; clear count, clear max_e to 0, best_idx=0, latch thresh.
  - SCAN: e_ready=1. A transfer occurs when e_valid&e_ready.
    - On each transfer, if count==0 or e_data > max_e (strict), then max_e<=e_data and best_idx<=count.
    - Ties keep the lower index.
    - count increments per transfer. The transfer with count==NUM_BEAMS-1 moves to CALC.
    - e_valid low stalls indefinitely with no timeout.
  - CALC: e_ready=0. Compute ANG_MIN + ANG_STEP*best_idx.
    - Multiply as shift-add (idx<<2)+idx for the default step.
    - Intermediate width is 9 bits signed; the result fits 8 bits signed (-90..90).
    - detect_next = (max_e >= thresh_latched).
    - Next state DONE.
  - DONE: angle, detect and wbdone registered on entry.
    - wbdone=1 for exactly this cycle, then -> IDLE.
- Latency: last sample accepted in cycle T; wbdone high in cycle T+2 with the new angle and detect valid in that same cycle.
- angle and detect change only on wbdone cycles.
- start in SCAN: err_restart pulses the next cycle. The scan restarts with counters cleared and thresh relatched, and the partial frame is discarded. A sample accepted in the same cycle as start is dropped; the new scan begins empty.
- start in CALC or DONE: ignored; the current result completes normally.
- start in the DONE cycle is also ignored; the upstream must reissue it.
- start and reset in the same cycle: reset wins.
- busy = state is SCAN or CALC. busy is low in the DONE cycle.
- Required parameter relation, checked by an elaboration assertion: ANG_MIN + ANG_STEP*(NUM_BEAMS-1) <= 127 and ANG_MIN >= -128.

Decomposition:
- Shared package beam_pkg: state enum (IDLE, SCAN, CALC, DONE), default NUM_BEAMS, ANG_MIN, ANG_STEP, ENERGY_W, and an index-width constant $clog2(NUM_BEAMS).
- No sub-module. The index-to-angle conversion is a function in beam_pkg (idx_to_angle) so the display bench can reuse it.

Test Plan:
- Reset, then a frame with the peak at index 18 (e_data=1000 at 18, 10 elsewhere), thresh=500 -> wbdone at T+2, angle=0, detect=1.
- Peak at index 0 and, in a separate frame, at index 36 -> angle=-90 (8'hA6), then angle=90 (8'h5A).
- Tie: equal max 700 at indices 5 and 20 -> angle=-65 (lower index wins). In a second frame with all samples equal -> angle=-90.
- Peak 400 at index 30 with thresh=500 -> angle=60, detect=0, wbdone pulses.
- Random e_valid gaps, plus start asserted after 10 samples -> err_restart pulses once. The next full frame with peak at index 7 gives angle=-55, and exactly one wbdone across the whole sequence.
- Reset asserted during CALC -> no wbdone; angle=0, detect=0. start during DONE -> ignored, block stays IDLE.
